// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a single-request memory controller.
// Several line-wide read/write clients share one request port, with exactly
// one request in flight at a time. Each read line or write ack is routed back
// to the client that issued it. A watchdog raises a sticky error if the memory
// controller never completes a request.
module mem_arbiter #(
    parameter int unsigned NumClients    = 4,
    parameter int unsigned AddrWidth     = 24,
    parameter int unsigned LineWidth     = 128,
    parameter int unsigned TimeoutCycles = 4096
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    // Client side
    input  logic [NumClients-1:0]           req_valid_i,
    input  logic [NumClients-1:0]           req_write_i,
    input  logic [NumClients*AddrWidth-1:0] req_addr_i,
    input  logic [NumClients*LineWidth-1:0] req_wdata_i,
    output logic [NumClients-1:0]           req_ready_o,
    output logic [NumClients-1:0]           resp_valid_o,
    output logic [LineWidth-1:0]            resp_data_o,
    output logic                            err_o,
    // Memory controller side
    input  logic                            mem_enabled_i,
    input  logic                            mem_ready_i,
    output logic                            mem_r_valid_o,
    output logic                            mem_w_valid_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [LineWidth-1:0]            mem_wdata_o,
    input  logic                            mem_r_valid_i,
    input  logic [LineWidth-1:0]            mem_rdata_i
);

    localparam int unsigned IdxW  = (NumClients > 1) ? $clog2(NumClients) : 1;
    // One spare bit so ptr + offset never wraps before the modulo correction.
    localparam int unsigned CandW = IdxW + 1;
    localparam int unsigned CntW  = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        ptr_q;
    logic [IdxW-1:0]        owner_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [LineWidth-1:0]   wdata_q;
    logic                   write_q;
    logic                   err_q;
    logic                   mem_r_valid_q;
    logic                   mem_w_valid_q;
    logic [NumClients-1:0]  resp_valid_q;
    logic [LineWidth-1:0]   resp_data_q;
    logic [CntW-1:0]        cnt_q;

    logic [IdxW-1:0]        winner;
    logic                   found;
    logic                   grant;
    logic [CandW-1:0]       cand;

    // Pick the first valid client after the last winner, wrapping modulo NumClients.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= NumClients; i++) begin
            cand = CandW'(ptr_q) + CandW'(i);
            if (cand >= CandW'(NumClients)) begin
                cand = cand - CandW'(NumClients);
            end
            if (!found && req_valid_i[cand[IdxW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IdxW-1:0];
            end
        end
    end

    // Grant only from idle, with the controller free and no latched error.
    always_comb begin
        grant       = (state_q == StIdle) && mem_enabled_i && mem_ready_i && found && !err_q;
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Request sequencing, watchdog and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            ptr_q         <= IdxW'(NumClients - 1);
            owner_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            err_q         <= 1'b0;
            mem_r_valid_q <= 1'b0;
            mem_w_valid_q <= 1'b0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
            cnt_q         <= '0;
        end else begin
            resp_valid_q  <= '0;
            mem_r_valid_q <= 1'b0;
            mem_w_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        addr_q        <= req_addr_i[winner*AddrWidth +: AddrWidth];
                        wdata_q       <= req_wdata_i[winner*LineWidth +: LineWidth];
                        write_q       <= req_write_i[winner];
                        owner_q       <= winner;
                        ptr_q         <= winner;
                        mem_r_valid_q <= !req_write_i[winner];
                        mem_w_valid_q <= req_write_i[winner];
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Reads finish on returned data, writes on the ready handshake.
                    if (write_q ? mem_ready_i : mem_r_valid_i) begin
                        resp_valid_q[owner_q] <= 1'b1;
                        if (!write_q) begin
                            resp_data_q <= mem_rdata_i;
                        end
                        state_q <= StIdle;
                    end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign resp_valid_o  = resp_valid_q;
    assign resp_data_o   = resp_data_q;
    assign err_o         = err_q;
    assign mem_r_valid_o = mem_r_valid_q;
    assign mem_w_valid_o = mem_w_valid_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;

endmodule
